prog_loader: RTL and testbench
==============================

# prog_loader

Byte-serial program loader for the 8-bit TinyTapeout CPU: the write-side counterpart of the CPU's instruction/data fetch from the 32-byte unified memory. It receives framed bytes from the host over the dedicated input pins and writes them into memory through the memory's write port. It holds the CPU in reset until a frame with a valid checksum completes. It sits between the pin interface (ui_in/uio_in) and the memory write port, alongside the CPU core.

## Interface
- MEM_DEPTH, 32, memory words; address width ADDR_W = clog2(MEM_DEPTH) = 5
- SYNC_BYTE, 8'hA5, frame start marker
- SYNC_STAGES, 2, flops in the strobe synchronizer (≥2)
- TIMEOUT_CYCLES, 1023, maximum idle clk cycles between bytes inside a frame
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- rx_strobe  in  1  host byte strobe, asynchronous to clk; a rising edge marks a new byte
- rx_data  in  8  host byte; stable from before the strobe rise until the strobe falls
- mem_we  out  1  memory write enable, one-cycle pulse
- mem_addr  out  ADDR_W  memory write address
- mem_wdata  out  8  memory write data
- cpu_hold  out  1  1 = keep CPU in reset
- busy  out  1  frame in progress (state ≠ IDLE)
- done  out  1  sticky: last frame completed with good checksum
- err  out  1  sticky: last frame had a bad checksum or timed out
- ack  out  1  toggles once per consumed byte (host flow control)

## Operation
- Frame format: SYNC_BYTE, ADDR (bits[4:0] = start address; bits[7:5] ignored), COUNT (1–31 literal; 0 means 32), COUNT data bytes, CHK.
- CHK = XOR of ADDR, COUNT and all data bytes. SYNC_BYTE is not included.
- FSM states: IDLE → ADDR → COUNT → DATA → CHECK → IDLE.
  - IDLE: bytes other than SYNC_BYTE are consumed and ignored. SYNC_BYTE moves to ADDR, clears done and err, and sets cpu_hold.
  - ADDR: latch the start address and seed the running XOR.
  - COUNT: latch the remaining count as a 6-bit value (0 → 32).
  - DATA: each byte triggers a write at the current pointer. The pointer increments modulo MEM_DEPTH (0x1F wraps to 0x00) and the count decrements. At count 0, move to CHECK. A SYNC_BYTE value here is ordinary data.
  - CHECK: if the byte equals the running XOR, set done and clear cpu_hold; otherwise set err and keep cpu_hold = 1. Return to IDLE.
- Data writes happen immediately, with no staging buffer. A bad frame may leave memory partially written, and cpu_hold stays asserted.
- Timeout: in any state ≠ IDLE, a counter reloads on every consumed byte. When it reaches TIMEOUT_CYCLES, go to IDLE with err = 1 and cpu_hold = 1.
- Reset values: state IDLE, cpu_hold = 1, mem_we = 0, mem_addr = 0, mem_wdata = 0, busy = 0, done = 0, err = 0, ack = 0.
- Reset mid-frame aborts the frame; memory contents are not touched.

## Timing
- rx_strobe passes through SYNC_STAGES flops, then a rising-edge detector. Pin rise in cycle t produces the internal byte pulse in cycle t+SYNC_STAGES (t+2 by default). rx_data is sampled in that cycle.
- A data byte's mem_we/mem_addr/mem_wdata are registered and valid in the cycle after the byte pulse (t+3). mem_we is high for exactly one cycle.
- ack toggles in the same cycle as the byte pulse + 1, for every consumed byte, including ignored IDLE bytes.
- The CHECK byte updates done/err/cpu_hold at pulse + 1.
- Minimum host byte spacing: strobe high ≥ SYNC_STAGES+1 cycles and low ≥ SYNC_STAGES+1 cycles.
- A byte pulse and a timeout in the same cycle: the byte wins and the counter reloads.

## Structure
- Shared package loader_pkg: FSM state enum (IDLE, ADDR, COUNT, DATA, CHECK), SYNC_BYTE default, frame field widths.
- Sub-module strobe_sync: SYNC_STAGES-deep synchronizer plus rising-edge pulse generator. prog_loader instantiates it once.
- Everything else (FSM, pointer, count, XOR, timeout counter) lives in prog_loader.

## Test plan
- Reset, then frame A5 03 02 8A 10 9B → writes 8A@0x03, 10@0x04; done=1, err=0, cpu_hold falls at the CHK byte + 1.
- Wrap: A5 1F 02 11 22 2E → writes 11@0x1F, 22@0x00; done=1.
- Bad checksum: A5 00 01 55 00 → 55@0x00 written; err=1, done=0, cpu_hold stays 1.
- Noise plus a data byte equal to the marker: 00 FF, then A5 05 01 A5 A1 → the leading bytes are ignored with two ack toggles; A5@0x05 is written; done=1.
- COUNT=0: A5 00 00, then 32 bytes 0x00–0x1F, then CHK = 0x00 → 32 writes covering the full memory; done=1.
- Timeout and reset: A5 04, then silence for TIMEOUT_CYCLES → err=1, state IDLE. Separately, assert reset mid-DATA → all outputs return to reset values and no further mem_we occurs.

Source files
------------

// File: rtl/prog_loader_pkg.sv
// Shared definitions for the byte-serial program loader: frame constants,
// field widths and the loader FSM state encoding.
package loader_pkg;

  localparam int MEM_DEPTH      = 32;
  localparam int ADDR_W         = $clog2(MEM_DEPTH);
  localparam int CNT_W          = ADDR_W + 1;
  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam int SYNC_STAGES    = 2;
  localparam int TIMEOUT_CYCLES = 1023;
  localparam int TMO_W          = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADDR  = 3'd1,
    COUNT = 3'd2,
    DATA  = 3'd3,
    CHECK = 3'd4
  } loader_state_t;

  // A zero count field means a full-memory frame.
  function automatic logic [CNT_W-1:0] decode_count(input logic [ADDR_W-1:0] field);
    return (field == '0) ? CNT_W'(MEM_DEPTH) : {1'b0, field};
  endfunction

endpackage

// File: rtl/prog_loader_if.sv
// Pin-side byte link plus memory write port and status of the program loader.
interface prog_loader_if import loader_pkg::*; ();

  // Byte link: host holds rx_data stable, raises rx_strobe (one rising edge per
  // byte), and the loader toggles ack once per consumed byte; the host waits for
  // that toggle (or the minimum spacing) before offering the next byte.
  logic                rx_strobe;
  logic [7:0]          rx_data;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic [7:0]          mem_wdata;
  logic                cpu_hold;
  logic                busy;
  logic                done;
  logic                err;
  logic                ack;
  loader_state_t       state;

  modport slave (
    input  rx_strobe, rx_data,
    output mem_we, mem_addr, mem_wdata, cpu_hold, busy, done, err, ack, state
  );

  modport master (
    output rx_strobe, rx_data,
    input  mem_we, mem_addr, mem_wdata, cpu_hold, busy, done, err, ack, state
  );

endinterface

// File: rtl/prog_loader_strobe_sync.sv
// Synchronizes the asynchronous host strobe and emits a one-cycle pulse on
// each rising edge, STAGES cycles after the pin rises.
module strobe_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic pulse
);

  logic [STAGES-1:0] sync_q;
  logic              last_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      last_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], async_in};
      last_q <= sync_q[STAGES-1];
    end
  end

  assign pulse = sync_q[STAGES-1] & ~last_q;

endmodule

// File: rtl/prog_loader.sv
// Byte-serial program loader: parses SYNC/ADDR/COUNT/DATA/CHK frames, writes
// memory directly and releases the CPU only after a good checksum.
module prog_loader import loader_pkg::*; (
  input  logic           clk,
  input  logic           reset,
  prog_loader_if.slave   bus
);

  logic                byte_pulse;
  loader_state_t       state;
  logic [ADDR_W-1:0]   ptr;
  logic [CNT_W-1:0]    cnt;
  logic [7:0]          xor_acc;
  logic [TMO_W-1:0]    tmo;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic [7:0]          mem_wdata;
  logic                cpu_hold;
  logic                done;
  logic                err;
  logic                ack;

  strobe_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk      (clk),
    .reset    (reset),
    .async_in (bus.rx_strobe),
    .pulse    (byte_pulse)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= '0;
      cnt       <= '0;
      xor_acc   <= '0;
      tmo       <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_hold  <= 1'b1;
      done      <= 1'b0;
      err       <= 1'b0;
      ack       <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      // A byte arriving in the same cycle as the timeout takes priority.
      if (byte_pulse) begin
        ack <= ~ack;
        tmo <= '0;
        case (state)
          IDLE: begin
            if (bus.rx_data == SYNC_BYTE) begin
              state    <= ADDR;
              done     <= 1'b0;
              err      <= 1'b0;
              cpu_hold <= 1'b1;
            end
          end
          ADDR: begin
            ptr     <= bus.rx_data[ADDR_W-1:0];
            xor_acc <= bus.rx_data;
            state   <= COUNT;
          end
          COUNT: begin
            cnt     <= decode_count(bus.rx_data[ADDR_W-1:0]);
            xor_acc <= xor_acc ^ bus.rx_data;
            state   <= DATA;
          end
          DATA: begin
            mem_we    <= 1'b1;
            mem_addr  <= ptr;
            mem_wdata <= bus.rx_data;
            ptr       <= ptr + ADDR_W'(1);
            cnt       <= cnt - CNT_W'(1);
            xor_acc   <= xor_acc ^ bus.rx_data;
            if (cnt == CNT_W'(1)) state <= CHECK;
          end
          CHECK: begin
            if (bus.rx_data == xor_acc) begin
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              err      <= 1'b1;
              cpu_hold <= 1'b1;
            end
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end else if (state != IDLE) begin
        if (tmo == TMO_W'(TIMEOUT_CYCLES)) begin
          state    <= IDLE;
          err      <= 1'b1;
          cpu_hold <= 1'b1;
          tmo      <= '0;
        end else begin
          tmo <= tmo + TMO_W'(1);
        end
      end
    end
  end

  assign bus.mem_we    = mem_we;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_wdata = mem_wdata;
  assign bus.cpu_hold  = cpu_hold;
  assign bus.busy      = (state != IDLE);
  assign bus.done      = done;
  assign bus.err       = err;
  assign bus.ack       = ack;
  assign bus.state     = state;

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: directed frames from the test plan plus
// randomized frames checked against a frame-level write/checksum model.
module tb_prog_loader;
  import loader_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  prog_loader_if bif();

  prog_loader dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
  );

  int tests = 0;
  int fails = 0;

  logic [ADDR_W+7:0] exp_q[$];
  logic              exp_ack;
  logic              hold_before;
  logic              hold_after;
  logic [7:0]        payload[32];
  logic [ADDR_W+7:0] mon_got;
  logic [ADDR_W+7:0] mon_exp;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required bench completion");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard: memory writes ----------------
  always @(negedge clk) begin
    if (bif.mem_we === 1'b1) begin
      tests++;
      mon_got = {bif.mem_addr, bif.mem_wdata};
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL write_unexpected: got addr=%h data=%h, required no write",
                 bif.mem_addr, bif.mem_wdata);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_got !== mon_exp) begin
          fails++;
          $display("FAIL write: got addr=%h data=%h, required addr=%h data=%h",
                   mon_got[ADDR_W+7:8], mon_got[7:0], mon_exp[ADDR_W+7:8], mon_exp[7:0]);
        end
      end
    end
  end

  // ---------------- reference model ----------------
  function automatic int frame_len(input logic [7:0] cnt_byte);
    return (cnt_byte[4:0] == 5'd0) ? MEM_DEPTH : int'(cnt_byte[4:0]);
  endfunction

  function automatic logic [7:0] frame_xor(input logic [7:0] addr, input logic [7:0] cnt_byte);
    logic [7:0] x;
    x = addr ^ cnt_byte;
    for (int i = 0; i < frame_len(cnt_byte); i++) x = x ^ payload[i];
    return x;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    bif.rx_data   = b;
    bif.rx_strobe = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 hold_before = bif.cpu_hold;
    @(posedge clk);
    #1 hold_after = bif.cpu_hold;
    exp_ack = ~exp_ack;
    tests++;
    if (bif.ack !== exp_ack) begin
      fails++;
      $display("FAIL ack_toggle: got %b, required %b (byte %h)", bif.ack, exp_ack, b);
    end
    repeat (2) @(negedge clk);
    bif.rx_strobe = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic run_frame(input logic [7:0] addr, input logic [7:0] cnt_byte,
                           input logic [7:0] chk, input string name);
    int n;
    logic good;
    n = frame_len(cnt_byte);
    good = (chk == frame_xor(addr, cnt_byte));
    for (int i = 0; i < n; i++)
      exp_q.push_back({ADDR_W'((int'(addr[4:0]) + i) % MEM_DEPTH), payload[i]});
    send_byte(SYNC_BYTE);
    send_byte(addr);
    send_byte(cnt_byte);
    for (int i = 0; i < n; i++) send_byte(payload[i]);
    send_byte(chk);
    tests++;
    if (hold_before !== 1'b1 || hold_after !== !good) begin
      fails++;
      $display("FAIL %s_hold_timing: got before=%b after=%b, required before=1 after=%b",
               name, hold_before, hold_after, !good);
    end
    tests++;
    if (bif.done !== good || bif.err !== !good) begin
      fails++;
      $display("FAIL %s_status: got done=%b err=%b, required done=%b err=%b",
               name, bif.done, bif.err, good, !good);
    end
    tests++;
    if (bif.busy !== 1'b0 || bif.state !== IDLE) begin
      fails++;
      $display("FAIL %s_idle: got busy=%b state=%0d, required busy=0 state=0",
               name, bif.busy, bif.state);
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL %s_writes: got %0d writes missing, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [21:0] got;
    reset = 1'b1;
    bif.rx_strobe = 1'b0;
    bif.rx_data = 8'h00;
    exp_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1 got = {bif.state, bif.cpu_hold, bif.mem_we, bif.mem_addr, bif.mem_wdata,
              bif.busy, bif.done, bif.err, bif.ack};
    tests++;
    if (got !== {IDLE, 1'b1, 1'b0, 5'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL reset_values: got %h, required %h", got,
               {IDLE, 1'b1, 1'b0, 5'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0});
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if (bif.cpu_hold !== 1'b1 || bif.busy !== 1'b0 || bif.ack !== 1'b0) begin
      fails++;
      $display("FAIL reset_release: got hold=%b busy=%b ack=%b, required 1 0 0",
               bif.cpu_hold, bif.busy, bif.ack);
    end
  endtask

  task automatic test_basic();
    payload[0] = 8'h8A; payload[1] = 8'h10;
    run_frame(8'h03, 8'h02, 8'h9B, "basic");
  endtask

  task automatic test_wrap();
    payload[0] = 8'h11; payload[1] = 8'h22;
    run_frame(8'h1F, 8'h02, 8'h2E, "wrap");
  endtask

  task automatic test_bad_chk();
    payload[0] = 8'h55;
    run_frame(8'h00, 8'h01, 8'h00, "bad_chk");
  endtask

  task automatic test_noise();
    send_byte(8'h00);
    send_byte(8'hFF);
    tests++;
    if (bif.busy !== 1'b0 || exp_q.size() != 0) begin
      fails++;
      $display("FAIL noise_ignored: got busy=%b, required busy=0", bif.busy);
    end
    payload[0] = SYNC_BYTE;
    run_frame(8'h05, 8'h01, 8'hA1, "marker_data");
  endtask

  task automatic test_count0();
    for (int i = 0; i < 32; i++) payload[i] = 8'(i);
    run_frame(8'h00, 8'h00, 8'h00, "count0");
  endtask

  task automatic test_random();
    logic [7:0] addr, cnt_byte, chk;
    int n;
    for (int f = 0; f < 6; f++) begin
      addr = 8'($urandom);
      n = $urandom_range(1, 32);
      cnt_byte = (n == 32) ? 8'h00 : 8'(n);
      for (int i = 0; i < n; i++)
        payload[i] = ($urandom_range(0, 7) == 0) ? SYNC_BYTE : 8'($urandom);
      chk = frame_xor(addr, cnt_byte);
      if ($urandom_range(0, 3) == 0) chk = chk ^ 8'($urandom_range(1, 255));
      run_frame(addr, cnt_byte, chk, "random");
    end
  endtask

  task automatic test_timeout();
    int n;
    send_byte(SYNC_BYTE);
    send_byte(8'h04);
    tests++;
    if (bif.busy !== 1'b1 || bif.done !== 1'b0 || bif.cpu_hold !== 1'b1) begin
      fails++;
      $display("FAIL timeout_mid: got busy=%b done=%b hold=%b, required 1 0 1",
               bif.busy, bif.done, bif.cpu_hold);
    end
    n = 0;
    while (bif.err !== 1'b1 && n < 1200) begin
      @(posedge clk);
      #1 n++;
    end
    tests++;
    if (n < 1000 || n > 1030) begin
      fails++;
      $display("FAIL timeout_delay: got %0d cycles of silence, required 1000..1030", n);
    end
    tests++;
    if (bif.err !== 1'b1 || bif.busy !== 1'b0 || bif.state !== IDLE ||
        bif.cpu_hold !== 1'b1 || bif.done !== 1'b0) begin
      fails++;
      $display("FAIL timeout_state: got err=%b busy=%b state=%0d hold=%b done=%b, required 1 0 0 1 0",
               bif.err, bif.busy, bif.state, bif.cpu_hold, bif.done);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [21:0] got;
    send_byte(SYNC_BYTE);
    send_byte(8'h00);
    send_byte(8'h05);
    exp_q.push_back({5'h00, 8'h11});
    send_byte(8'h11);
    exp_q.push_back({5'h01, 8'h22});
    send_byte(8'h22);
    @(negedge clk);
    reset = 1'b1;
    exp_ack = 1'b0;
    @(posedge clk);
    #1 got = {bif.state, bif.cpu_hold, bif.mem_we, bif.mem_addr, bif.mem_wdata,
              bif.busy, bif.done, bif.err, bif.ack};
    tests++;
    if (got !== {IDLE, 1'b1, 1'b0, 5'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL midframe_reset_values: got %h, required %h", got,
               {IDLE, 1'b1, 1'b0, 5'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0});
    end
    @(negedge clk);
    reset = 1'b0;
    send_byte(8'h33);
    send_byte(8'h44);
    tests++;
    if (bif.busy !== 1'b0 || exp_q.size() != 0) begin
      fails++;
      $display("FAIL midframe_abort: got busy=%b pending=%0d, required busy=0 pending=0",
               bif.busy, exp_q.size());
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_bad_chk();
    test_noise();
    test_count0();
    test_random();
    test_timeout();
    test_reset_mid_frame();
    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
